mem_arbiter: RTL and testbench

- Sequences and shares the single byte-serial memory controller between the instruction cache (fetch) and the load/store buffer (LSB).
- Owns request latching, priority with anti-starvation, the UART-full stall for IO stores, pipeline-flush draining and load-data masking.
- Sits between ic/LSB and the memory controller's request/done interface.

---
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, load/store and memory-controller signal bundle for mem_arbiter
interface mem_arbiter_if;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_done;
    logic [31:0] ic_data;

    logic        lsb_req;
    logic        lsb_wr;
    logic [31:0] lsb_addr;
    logic [2:0]  lsb_size;
    logic [31:0] lsb_wdata;
    logic        lsb_done;
    logic [31:0] lsb_rdata;

    logic        mc_valid;
    logic        mc_wr;
    logic [31:0] mc_addr;
    logic [2:0]  mc_size;
    logic [31:0] mc_wdata;
    logic        mc_done;
    logic [31:0] mc_rdata;

    // master: the arbiter itself; slave: requesters plus memory controller
    modport master (
        input  ic_req, ic_addr,
        input  lsb_req, lsb_wr, lsb_addr, lsb_size, lsb_wdata,
        input  mc_done, mc_rdata,
        output ic_done, ic_data, lsb_done, lsb_rdata,
        output mc_valid, mc_wr, mc_addr, mc_size, mc_wdata
    );

    modport slave (
        output ic_req, ic_addr,
        output lsb_req, lsb_wr, lsb_addr, lsb_size, lsb_wdata,
        output mc_done, mc_rdata,
        input  ic_done, ic_data, lsb_done, lsb_rdata,
        input  mc_valid, mc_wr, mc_addr, mc_size, mc_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one byte-serial memory controller between fetch and the load/store buffer
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rdy,
    input  logic           flush,
    input  logic           io_buffer_full,
    mem_arbiter_if.master  bus
);

    typedef enum logic [1:0] {IDLE, BUSY_IC, BUSY_LSB, GAP} state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             drain, drain_next;

    logic io_block;
    logic lsb_elig;
    logic ic_elig;
    logic starved;
    logic drainable;
    logic grant_ic;
    logic grant_lsb;
    logic complete;
    logic kill;

    function automatic logic [31:0] size_mask(input logic [2:0] size);
        case (size)
            3'd1:    return 32'h0000_00FF;
            3'd2:    return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    always_comb begin
        io_block   = bus.lsb_wr && (bus.lsb_addr[17:16] == 2'b11) && io_buffer_full;
        // a flush kills loads that have not started, but committed stores still go
        lsb_elig   = bus.lsb_req && !io_block && !(flush && !bus.lsb_wr);
        ic_elig    = bus.ic_req && !flush;
        starved    = (cnt == LIMIT);
        drainable  = (state == BUSY_IC) || ((state == BUSY_LSB) && !bus.mc_wr);

        state_next = state;
        drain_next = drain;
        grant_ic   = 1'b0;
        grant_lsb  = 1'b0;
        complete   = 1'b0;
        kill       = 1'b0;

        case (state)
            IDLE: begin
                if (ic_elig && (!lsb_elig || starved)) begin
                    grant_ic   = 1'b1;
                    state_next = BUSY_IC;
                end else if (lsb_elig) begin
                    grant_lsb  = 1'b1;
                    state_next = BUSY_LSB;
                end
            end
            BUSY_IC, BUSY_LSB: begin
                if (flush && drainable) begin
                    drain_next = 1'b1;
                end
                if (bus.mc_done) begin
                    complete   = 1'b1;
                    kill       = drain || (flush && drainable);
                    drain_next = 1'b0;
                    state_next = GAP;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (!bus.ic_req || grant_ic) begin
            cnt_next = '0;
        end else if (grant_lsb && !starved) begin
            cnt_next = cnt + CNT_W'(1);
        end else begin
            cnt_next = cnt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            drain <= 1'b0;
        end else if (rdy) begin
            state <= state_next;
            cnt   <= cnt_next;
            drain <= drain_next;
        end
    end

    // mc_wr/mc_size double as the latched owner attributes for the whole transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.mc_valid  <= 1'b0;
            bus.mc_wr     <= 1'b0;
            bus.mc_addr   <= '0;
            bus.mc_size   <= '0;
            bus.mc_wdata  <= '0;
            bus.ic_done   <= 1'b0;
            bus.ic_data   <= '0;
            bus.lsb_done  <= 1'b0;
            bus.lsb_rdata <= '0;
        end else if (rdy) begin
            bus.ic_done  <= 1'b0;
            bus.lsb_done <= 1'b0;

            if (grant_ic) begin
                bus.mc_valid <= 1'b1;
                bus.mc_wr    <= 1'b0;
                bus.mc_addr  <= bus.ic_addr;
                bus.mc_size  <= 3'd4;
                bus.mc_wdata <= '0;
            end else if (grant_lsb) begin
                bus.mc_valid <= 1'b1;
                bus.mc_wr    <= bus.lsb_wr;
                bus.mc_addr  <= bus.lsb_addr;
                bus.mc_size  <= bus.lsb_size;
                bus.mc_wdata <= bus.lsb_wdata;
            end

            if (complete) begin
                bus.mc_valid <= 1'b0;
                if (!kill) begin
                    if (state == BUSY_IC) begin
                        bus.ic_done <= 1'b1;
                        bus.ic_data <= bus.mc_rdata;
                    end else begin
                        bus.lsb_done  <= 1'b1;
                        bus.lsb_rdata <= bus.mc_rdata & size_mask(bus.mc_size);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
    localparam int STARVE = 4;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic flush;
    logic io_buffer_full;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_LIMIT(STARVE), .CNT_W(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .flush          (flush),
        .io_buffer_full (io_buffer_full),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic ic;
        logic lsb;
        logic wr;
        logic io;
        logic full;
        logic fl;
        int   exp;   // 0 none, 1 IC, 2 LSB
    } elig_t;

    typedef struct {
        logic [2:0]  size;
        logic [31:0] rdata;
        logic [31:0] exp;
    } mask_t;

    elig_t ev[12];
    mask_t mv[7];

    // reference model state (transaction level)
    int          m_phase;   // 0 idle, 1 busy, 2 gap
    int          m_owner;   // 1 IC, 2 LSB
    int          m_cnt;
    bit          m_drain;
    logic        e_mc_valid, e_mc_wr, e_ic_done, e_lsb_done;
    logic [31:0] e_mc_addr, e_mc_wdata, e_ic_data, e_lsb_rdata;
    logic [2:0]  e_mc_size;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.ic_req     = 1'b0;
        bus.lsb_req    = 1'b0;
        bus.mc_done    = 1'b0;
        flush          = 1'b0;
        io_buffer_full = 1'b0;
    endtask

    task automatic settle();
        quiet();
        repeat (3) step();
    endtask

    task automatic done_cycle(input logic [31:0] rd);
        bus.mc_rdata = rd;
        bus.mc_done  = 1'b1;
        step();
        bus.mc_done  = 1'b0;
    endtask

    task automatic lsb_set(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] wdata);
        bus.lsb_req   = 1'b1;
        bus.lsb_wr    = wr;
        bus.lsb_addr  = addr;
        bus.lsb_size  = size;
        bus.lsb_wdata = wdata;
    endtask

    task automatic model_edge();
        bit stall, l_ok, i_ok, gi, gl, killable;
        int bytes;
        if (!rdy) return;
        e_ic_done  = 1'b0;
        e_lsb_done = 1'b0;
        gi = 1'b0;
        gl = 1'b0;
        if (m_phase == 0) begin
            stall = bus.lsb_wr && (bus.lsb_addr[17:16] == 2'b11) && io_buffer_full;
            l_ok  = bus.lsb_req && !stall && (bus.lsb_wr || !flush);
            i_ok  = bus.ic_req && !flush;
            gi    = i_ok && (!l_ok || m_cnt >= STARVE);
            gl    = l_ok && !gi;
            if (gi) begin
                m_phase = 1; m_owner = 1;
                e_mc_valid = 1'b1; e_mc_wr = 1'b0; e_mc_addr = bus.ic_addr; e_mc_size = 3'd4;
            end
            if (gl) begin
                m_phase = 1; m_owner = 2;
                e_mc_valid = 1'b1; e_mc_wr = bus.lsb_wr; e_mc_addr = bus.lsb_addr;
                e_mc_size = bus.lsb_size; e_mc_wdata = bus.lsb_wdata;
            end
        end else if (m_phase == 1) begin
            killable = (m_owner == 1) || !e_mc_wr;
            if (flush && killable) m_drain = 1'b1;
            if (bus.mc_done) begin
                e_mc_valid = 1'b0;
                m_phase    = 2;
                if (!m_drain) begin
                    if (m_owner == 1) begin
                        e_ic_done = 1'b1;
                        e_ic_data = bus.mc_rdata;
                    end else begin
                        e_lsb_done  = 1'b1;
                        bytes       = (e_mc_size == 3'd1) ? 1 : (e_mc_size == 3'd2) ? 2 : 4;
                        e_lsb_rdata = 32'(64'(bus.mc_rdata) % (64'd1 << (8 * bytes)));
                    end
                end
                m_drain = 1'b0;
            end
        end else begin
            m_phase = 0;
        end
        if (!bus.ic_req || gi) m_cnt = 0;
        else if (gl && m_cnt < STARVE) m_cnt++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] laddr;
        logic [2:0]  sizes [5];
        bit          ic_pend, lsb_pend;
        int          w;

        rst = 1'b0; rdy = 1'b1;
        quiet();
        bus.ic_addr = '0; bus.lsb_wr = 1'b0; bus.lsb_addr = '0; bus.lsb_size = 3'd4;
        bus.lsb_wdata = '0; bus.mc_rdata = '0;
        step(); step();
        chk("reset_mc_valid", bus.mc_valid, 0);
        chk("reset_mc_addr", bus.mc_addr, 0);
        chk("reset_mc_size", bus.mc_size, 0);
        chk("reset_ic_done", bus.ic_done, 0);
        chk("reset_lsb_done", bus.lsb_done, 0);
        chk("reset_lsb_rdata", bus.lsb_rdata, 0);
        rst = 1'b1;
        step();

        // fetch only, with grant latency and post-done gap
        bus.ic_req = 1'b1; bus.ic_addr = 32'h100;
        step();
        chk("fetch_grant_valid", bus.mc_valid, 1);
        chk("fetch_grant_addr", bus.mc_addr, 32'h100);
        chk("fetch_grant_size", bus.mc_size, 4);
        chk("fetch_grant_wr", bus.mc_wr, 0);
        repeat (4) step();
        chk("fetch_busy_valid", bus.mc_valid, 1);
        bus.mc_rdata = 32'h13; bus.mc_done = 1'b1;
        bus.ic_addr = 32'h104;
        step();
        bus.mc_done = 1'b0;
        chk("fetch_done", bus.ic_done, 1);
        chk("fetch_data", bus.ic_data, 32'h13);
        chk("fetch_done_valid", bus.mc_valid, 0);
        step();
        chk("fetch_gap_valid", bus.mc_valid, 0);
        chk("fetch_done_one_cycle", bus.ic_done, 0);
        step();
        chk("fetch_regrant_valid", bus.mc_valid, 1);
        chk("fetch_regrant_addr", bus.mc_addr, 32'h104);
        done_cycle(32'h0);
        settle();

        // eligibility / priority table, each row from IDLE with a cleared counter
        ev[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        ev[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        ev[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        ev[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1};
        ev[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0};
        ev[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2};
        ev[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2};
        ev[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        ev[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        ev[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2};
        ev[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        ev[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0};
        for (int i = 0; i < 12; i++) begin
            laddr = ev[i].io ? 32'h0003_0010 : 32'h0000_2010;
            bus.ic_req = ev[i].ic; bus.ic_addr = 32'h100;
            lsb_set(ev[i].wr, laddr, 3'd4, 32'h5A5A_0000 + i);
            bus.lsb_req = ev[i].lsb;
            io_buffer_full = ev[i].full;
            flush = ev[i].fl;
            step();
            chk($sformatf("elig%0d_valid", i), bus.mc_valid, ev[i].exp != 0);
            if (ev[i].exp != 0) begin
                chk($sformatf("elig%0d_addr", i), bus.mc_addr, (ev[i].exp == 1) ? 32'h100 : laddr);
                chk($sformatf("elig%0d_wr", i), bus.mc_wr, (ev[i].exp == 2) && ev[i].wr);
            end
            quiet();
            bus.mc_done = (ev[i].exp != 0);
            step();
            settle();
        end

        // load masking table
        mv[0] = '{3'd1, 32'hDEAD_BEEF, 32'h0000_00EF};
        mv[1] = '{3'd2, 32'hDEAD_BEEF, 32'h0000_BEEF};
        mv[2] = '{3'd4, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        mv[3] = '{3'd0, 32'h1234_5678, 32'h1234_5678};
        mv[4] = '{3'd3, 32'hCAFE_F00D, 32'hCAFE_F00D};
        mv[5] = '{3'd7, 32'h8899_AABB, 32'h8899_AABB};
        mv[6] = '{3'd1, 32'h0000_0180, 32'h0000_0080};
        for (int i = 0; i < 7; i++) begin
            lsb_set(1'b0, 32'h2001, mv[i].size, 32'h0);
            step();
            chk($sformatf("mask%0d_size", i), bus.mc_size, mv[i].size);
            done_cycle(mv[i].rdata);
            chk($sformatf("mask%0d_done", i), bus.lsb_done, 1);
            chk($sformatf("mask%0d_rdata", i), bus.lsb_rdata, mv[i].exp);
            settle();
        end

        // IO store stalled behind a full UART buffer
        lsb_set(1'b1, 32'h0003_0000, 3'd4, 32'hA5A5_1234);
        io_buffer_full = 1'b1;
        bus.ic_req = 1'b1; bus.ic_addr = 32'h300;
        step();
        chk("io_ic_first", bus.mc_addr, 32'h300);
        done_cycle(32'h0);
        bus.ic_req = 1'b0;
        step(); step();
        chk("io_store_held", bus.mc_valid, 0);
        io_buffer_full = 1'b0;
        step();
        chk("io_store_valid", bus.mc_valid, 1);
        chk("io_store_wr", bus.mc_wr, 1);
        chk("io_store_addr", bus.mc_addr, 32'h0003_0000);
        chk("io_store_wdata", bus.mc_wdata, 32'hA5A5_1234);
        done_cycle(32'h0);
        chk("io_store_done", bus.lsb_done, 1);
        settle();

        // starvation: IC forced in after STARVE consecutive LSB grants
        bus.ic_req = 1'b1; bus.ic_addr = 32'h200;
        lsb_set(1'b0, 32'h2000, 3'd4, 32'h0);
        for (int g = 0; g < 10; g++) begin
            w = 0;
            do begin step(); w++; end while (!bus.mc_valid && w < 6);
            chk($sformatf("starve%0d_valid", g), bus.mc_valid, 1);
            chk($sformatf("starve%0d_owner", g), bus.mc_addr, ((g % 5) == 4) ? 32'h200 : 32'h2000);
            done_cycle(32'h0);
        end
        settle();

        // flush during a fetch
        bus.ic_req = 1'b1; bus.ic_addr = 32'h400;
        step();
        done_cycle(32'h0BAD_F00D);
        chk("pre_flush_ic_data", bus.ic_data, 32'h0BAD_F00D);
        settle();
        bus.ic_req = 1'b1; bus.ic_addr = 32'h404;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0; bus.ic_req = 1'b0;
        step();
        chk("flush_ic_hold_valid", bus.mc_valid, 1);
        done_cycle(32'h1111_1111);
        chk("flush_ic_no_done", bus.ic_done, 0);
        chk("flush_ic_valid_drop", bus.mc_valid, 0);
        chk("flush_ic_data_kept", bus.ic_data, 32'h0BAD_F00D);
        settle();

        // flush during a load
        lsb_set(1'b0, 32'h2004, 3'd4, 32'h0);
        step();
        done_cycle(32'h5555_AAAA);
        settle();
        lsb_set(1'b0, 32'h2008, 3'd4, 32'h0);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0; bus.lsb_req = 1'b0;
        chk("flush_ld_hold_valid", bus.mc_valid, 1);
        done_cycle(32'h1234_5678);
        chk("flush_ld_no_done", bus.lsb_done, 0);
        chk("flush_ld_rdata_kept", bus.lsb_rdata, 32'h5555_AAAA);
        settle();

        // flush during a committed store
        lsb_set(1'b1, 32'h200C, 3'd4, 32'h7777_0001);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        done_cycle(32'h0);
        chk("flush_st_done", bus.lsb_done, 1);
        settle();

        // flush coincident with mc_done on a load
        lsb_set(1'b0, 32'h2010, 3'd4, 32'h0);
        step();
        flush = 1'b1;
        done_cycle(32'h9999_9999);
        flush = 1'b0; bus.lsb_req = 1'b0;
        chk("flush_coinc_no_done", bus.lsb_done, 0);
        settle();

        // rdy low freezes completion and the done pulse
        lsb_set(1'b0, 32'h2100, 3'd2, 32'h0);
        step();
        bus.mc_rdata = 32'hCAFE_BABE; bus.mc_done = 1'b1; rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rdy_hold%0d_valid", i), bus.mc_valid, 1);
            chk($sformatf("rdy_hold%0d_done", i), bus.lsb_done, 0);
        end
        rdy = 1'b1;
        step();
        bus.mc_done = 1'b0;
        chk("rdy_resume_done", bus.lsb_done, 1);
        chk("rdy_resume_rdata", bus.lsb_rdata, 32'h0000_BABE);
        bus.lsb_req = 1'b0; rdy = 1'b0;
        step(); step();
        chk("rdy_done_held", bus.lsb_done, 1);
        rdy = 1'b1;
        step();
        chk("rdy_done_cleared", bus.lsb_done, 0);
        settle();

        // asynchronous reset in BUSY_LSB
        lsb_set(1'b0, 32'h2200, 3'd4, 32'h0);
        step();
        chk("arst_pre_valid", bus.mc_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", bus.mc_valid, 0);
        chk("arst_addr", bus.mc_addr, 0);
        chk("arst_rdata", bus.lsb_rdata, 0);
        quiet();
        step();
        rst = 1'b1;
        step();

        // randomized traffic against the reference model
        sizes[0] = 3'd1; sizes[1] = 3'd2; sizes[2] = 3'd4; sizes[3] = 3'd0; sizes[4] = 3'd3;
        m_phase = 0; m_owner = 0; m_cnt = 0; m_drain = 1'b0;
        e_mc_valid = 1'b0; e_mc_wr = 1'b0; e_ic_done = 1'b0; e_lsb_done = 1'b0;
        e_mc_addr = '0; e_mc_wdata = '0; e_ic_data = '0; e_lsb_rdata = '0; e_mc_size = '0;
        ic_pend = 1'b0; lsb_pend = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rdy            = ($urandom_range(0, 7) != 0);
            flush          = rdy && ($urandom_range(0, 19) == 0);
            io_buffer_full = ($urandom_range(0, 2) == 0);
            if (!ic_pend && $urandom_range(0, 1) == 1) begin
                ic_pend = 1'b1;
                bus.ic_addr = $urandom & 32'hFFFF_FFFC;
            end
            bus.ic_req = ic_pend;
            if (!lsb_pend && $urandom_range(0, 1) == 1) begin
                lsb_pend = 1'b1;
                lsb_set($urandom_range(0, 1) == 1, $urandom, sizes[$urandom_range(0, 4)], $urandom);
            end
            bus.lsb_req  = lsb_pend;
            bus.mc_done  = (m_phase == 1) && ($urandom_range(0, 2) == 0);
            bus.mc_rdata = $urandom;
            model_edge();
            step();
            chk("rnd_mc_valid", bus.mc_valid, e_mc_valid);
            chk("rnd_ic_done", bus.ic_done, e_ic_done);
            chk("rnd_lsb_done", bus.lsb_done, e_lsb_done);
            if (e_mc_valid) begin
                chk("rnd_mc_addr", bus.mc_addr, e_mc_addr);
                chk("rnd_mc_wr", bus.mc_wr, e_mc_wr);
                chk("rnd_mc_size", bus.mc_size, e_mc_size);
                if (e_mc_wr) chk("rnd_mc_wdata", bus.mc_wdata, e_mc_wdata);
            end
            if (e_ic_done) chk("rnd_ic_data", bus.ic_data, e_ic_data);
            if (e_lsb_done && !e_mc_wr) chk("rnd_lsb_rdata", bus.lsb_rdata, e_lsb_rdata);
            if (e_ic_done) ic_pend = 1'b0;
            if (e_lsb_done) lsb_pend = 1'b0;
            if (flush) begin
                ic_pend = 1'b0;
                if (!bus.lsb_wr) lsb_pend = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
